// File: rtl/stopwatch_lap_core.sv
// Stopwatch/timer core: self-generated tick, up/down mm:ss.cc counting,
// lap capture FIFO and a display-hold latch in front of the segment encoder.
module stopwatch_lap_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MAX_MINS  = 99,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         CLK_50,
    input  logic                         reset_n,
    input  logic                         start_stop,
    input  logic                         clear,
    input  logic                         mode_down,
    input  logic                         load,
    input  logic [6:0]                   load_mins,
    input  logic [5:0]                   load_secs,
    input  logic                         hold,
    input  logic                         lap,
    input  logic                         lap_pop,
    output logic [6:0]                   disp_mins,
    output logic [5:0]                   disp_secs,
    output logic [6:0]                   disp_decs,
    output logic [19:0]                  lap_head,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_full,
    output logic                         running,
    output logic                         overflow_flag,
    output logic                         done_flag
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PW   = $clog2(DIV);
    localparam int AW   = $clog2(LAP_DEPTH);
    localparam int CW   = AW + 1;
    localparam int STEP = (TICK_HZ < 100) ? (100 / TICK_HZ) : 1;

    typedef enum logic [2:0] {IDLE, RUN, PAUSE, OVF, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [6:0]      mins, decs;
    logic [5:0]      secs;
    logic            dir_down;
    logic [19:0]     mem [LAP_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;

    logic [6:0]      nx_mins, nx_decs;
    logic [5:0]      nx_secs;
    logic [7:0]      d_up;
    logic            hit;
    logic            lap_ok, do_pop, do_push, time_zero;

    // Next time value for one tick; hit marks reaching the count limit.
    always_comb begin
        nx_mins = mins;
        nx_secs = secs;
        nx_decs = decs;
        hit     = 1'b0;
        d_up    = {1'b0, decs} + 8'(STEP);
        if (!dir_down) begin
            if (d_up > 8'd99) begin
                nx_decs = 7'(d_up - 8'd100);
                if (secs == 6'd59) begin
                    nx_secs = '0;
                    if (mins == 7'(MAX_MINS)) begin
                        hit     = 1'b1;
                        nx_mins = 7'(MAX_MINS);
                        nx_secs = 6'd59;
                        nx_decs = 7'd99;
                    end else begin
                        nx_mins = mins + 7'd1;
                    end
                end else begin
                    nx_secs = secs + 6'd1;
                end
            end else begin
                nx_decs = d_up[6:0];
            end
        end else if (mins == '0 && secs == '0 && decs <= 7'(STEP)) begin
            hit     = 1'b1;
            nx_decs = '0;
        end else if (decs < 7'(STEP)) begin
            nx_decs = 7'({1'b0, decs} + 8'd100 - 8'(STEP));
            if (secs == '0) begin
                nx_secs = 6'd59;
                nx_mins = mins - 7'd1;
            end else begin
                nx_secs = secs - 6'd1;
            end
        end else begin
            nx_decs = decs - 7'(STEP);
        end
    end

    assign time_zero = ({mins, secs, decs} == '0);
    assign lap_ok    = (state == RUN) || (state == PAUSE);
    assign lap_full  = (lap_count == CW'(LAP_DEPTH));
    assign do_pop    = lap_pop && (lap_count != '0);
    assign do_push   = lap && lap_ok && (!lap_full || do_pop);
    assign lap_head  = (lap_count == '0) ? '0 : mem[rd_ptr];
    assign running   = (state == RUN);

    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            presc         <= '0;
            mins          <= '0;
            secs          <= '0;
            decs          <= '0;
            dir_down      <= 1'b0;
            overflow_flag <= 1'b0;
            done_flag     <= 1'b0;
            disp_mins     <= '0;
            disp_secs     <= '0;
            disp_decs     <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            lap_count     <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (!hold) {disp_mins, disp_secs, disp_decs} <= {mins, secs, decs};

            if (clear) begin
                state         <= IDLE;
                presc         <= '0;
                mins          <= '0;
                secs          <= '0;
                decs          <= '0;
                dir_down      <= 1'b0;
                overflow_flag <= 1'b0;
                done_flag     <= 1'b0;
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                lap_count     <= '0;
            end else begin
                // Lap captures the time as it stands before this edge.
                if (do_pop) rd_ptr <= rd_ptr + 1'b1;
                if (do_push) begin
                    mem[wr_ptr] <= {mins, secs, decs};
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                lap_count <= lap_count + CW'(do_push) - CW'(do_pop);

                case (state)
                    IDLE: begin
                        if (load) begin
                            mins <= (load_mins > 7'(MAX_MINS)) ? 7'(MAX_MINS) : load_mins;
                            secs <= (load_secs > 6'd59) ? 6'd59 : load_secs;
                            decs <= '0;
                        end else if (start_stop && !(mode_down && time_zero)) begin
                            state    <= RUN;
                            presc    <= '0;
                            dir_down <= mode_down;
                        end
                    end
                    RUN: begin
                        if (start_stop) begin
                            state <= PAUSE;
                        end else if (presc == PW'(DIV - 1)) begin
                            presc <= '0;
                            mins  <= nx_mins;
                            secs  <= nx_secs;
                            decs  <= nx_decs;
                            if (hit) begin
                                state <= dir_down ? DONE : OVF;
                                if (dir_down) done_flag <= 1'b1;
                                else          overflow_flag <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (start_stop) begin
                            state <= RUN;
                            presc <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Bench for stopwatch_lap_core: time kept as total hundredths, laps in a queue,
// compared against every DUT output once per cycle plus directed spot checks.
module tb_stopwatch_lap_core;

    localparam int MAXM  = 1;
    localparam int DEPTH = 4;
    localparam int MAX_T = MAXM * 6000 + 5999;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVF = 3, S_DONE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_stop, clear, mode_down, load, hold, lap, lap_pop;
    logic [6:0]  load_mins;
    logic [5:0]  load_secs;
    logic [6:0]  disp_mins, disp_decs;
    logic [5:0]  disp_secs;
    logic [19:0] lap_head;
    logic [2:0]  lap_count;
    logic        lap_full, running, overflow_flag, done_flag;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int m_st, m_t, m_cnt, m_disp;
    bit m_down, m_ovf, m_done;
    int q[$];

    always #5 clk = ~clk;

    stopwatch_lap_core #(
        .CLK_HZ(1000), .TICK_HZ(100), .MAX_MINS(MAXM), .LAP_DEPTH(DEPTH)
    ) dut (
        .CLK_50(clk), .reset_n(rst_n), .start_stop(start_stop), .clear(clear),
        .mode_down(mode_down), .load(load), .load_mins(load_mins), .load_secs(load_secs),
        .hold(hold), .lap(lap), .lap_pop(lap_pop),
        .disp_mins(disp_mins), .disp_secs(disp_secs), .disp_decs(disp_decs),
        .lap_head(lap_head), .lap_count(lap_count), .lap_full(lap_full),
        .running(running), .overflow_flag(overflow_flag), .done_flag(done_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [19:0] enc(input int t);
        return {7'(t / 6000), 6'((t / 100) % 60), 7'(t % 100)};
    endfunction

    task automatic mreset();
        m_st = S_IDLE; m_t = 0; m_cnt = 0; m_disp = 0;
        m_down = 0; m_ovf = 0; m_done = 0;
        q.delete();
    endtask

    task automatic model_update();
        int  old_t, lm, ls;
        bit  popok, pushok;
        if (!rst_n) begin mreset(); return; end
        old_t = m_t;
        if (!hold) m_disp = old_t;
        if (clear) begin
            m_st = S_IDLE; m_t = 0; m_cnt = 0; m_ovf = 0; m_done = 0; m_down = 0;
            q.delete();
            return;
        end
        popok  = lap_pop && q.size() > 0;
        pushok = lap && (m_st == S_RUN || m_st == S_PAUSE) && (q.size() < DEPTH || popok);
        if (popok)  void'(q.pop_front());
        if (pushok) q.push_back(old_t);
        case (m_st)
            S_IDLE: begin
                if (load) begin
                    lm  = (int'(load_mins) > MAXM) ? MAXM : int'(load_mins);
                    ls  = (int'(load_secs) > 59) ? 59 : int'(load_secs);
                    m_t = lm * 6000 + ls * 100;
                end else if (start_stop && !(mode_down && m_t == 0)) begin
                    m_st = S_RUN; m_cnt = 0; m_down = mode_down;
                end
            end
            S_RUN: begin
                if (start_stop) m_st = S_PAUSE;
                else begin
                    m_cnt++;
                    if (m_cnt == 10) begin
                        m_cnt = 0;
                        if (m_down) begin
                            m_t--;
                            if (m_t <= 0) begin m_t = 0; m_st = S_DONE; m_done = 1; end
                        end else begin
                            m_t++;
                            if (m_t > MAX_T) begin m_t = MAX_T; m_st = S_OVF; m_ovf = 1; end
                        end
                    end
                end
            end
            S_PAUSE: if (start_stop) begin m_st = S_RUN; m_cnt = 0; end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("disp", {disp_mins, disp_secs, disp_decs}, enc(m_disp));
        chk("lap_head", lap_head, (q.size() > 0) ? enc(q[0]) : 20'd0);
        chk("lap_count", lap_count, q.size());
        chk("lap_full", lap_full, q.size() == DEPTH);
        chk("running", running, m_st == S_RUN);
        chk("overflow_flag", overflow_flag, m_ovf);
        chk("done_flag", done_flag, m_done);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start();
        start_stop = 1'b1; step(); start_stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic do_load(input logic [6:0] mm, input logic [5:0] ss);
        load_mins = mm; load_secs = ss; load = 1'b1; step(); load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {start_stop, clear, mode_down, load, hold, lap, lap_pop} = '0;
        load_mins = '0; load_secs = '0;
        mreset();
        #12;
        chk("rst_disp", {disp_mins, disp_secs, disp_decs}, 20'd0);
        chk("rst_lap_count", lap_count, 0);
        chk("rst_running", running, 0);
        step();
        rst_n = 1'b1;
        idle(3);

        // minute boundary while counting up
        do_load(7'd0, 6'd59);
        pulse_start();
        idle(1001);
        chk("min_wrap", {disp_mins, disp_secs, disp_decs}, {7'd1, 6'd0, 7'd0});

        // saturating load, then overflow at 01:59.99
        do_clear();
        do_load(7'd100, 6'd63);
        pulse_start();
        idle(999);
        chk("pre_ovf", {disp_mins, disp_secs, disp_decs}, {7'd1, 6'd59, 7'd99});
        chk("pre_ovf_flag", overflow_flag, 0);
        idle(1);
        chk("ovf_flag", overflow_flag, 1);
        idle(20);
        chk("ovf_frozen", {disp_mins, disp_secs, disp_decs}, {7'd1, 6'd59, 7'd99});
        pulse_start();
        idle(2);
        chk("ovf_ignores_start", running, 0);

        // down count to zero
        do_clear();
        mode_down = 1'b1;
        pulse_start();
        chk("dn_zero_start_ignored", running, 0);
        do_load(7'd0, 6'd1);
        pulse_start();
        idle(999);
        chk("dn_pre_done", done_flag, 0);
        idle(1);
        chk("dn_done", done_flag, 1);
        idle(1);
        chk("dn_zero", {disp_mins, disp_secs, disp_decs}, 20'd0);
        pulse_start();
        idle(2);
        chk("done_ignores_start", running, 0);
        mode_down = 1'b0;

        // pause at 37, resume restarts the prescaler
        do_clear();
        pulse_start();
        idle(370);
        pulse_start();
        idle(500);
        chk("pause_hold", {disp_mins, disp_secs, disp_decs}, 20'd37);
        pulse_start();
        idle(10);
        chk("resume_pre", {disp_mins, disp_secs, disp_decs}, 20'd37);
        idle(1);
        chk("resume_tick", {disp_mins, disp_secs, disp_decs}, 20'd38);

        // lap FIFO fill, overfill, pop+push when full, drain
        do_clear();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            idle(10);
            lap = 1'b1; step(); lap = 1'b0;
        end
        chk("lap_count_full", lap_count, 4);
        chk("lap_full", lap_full, 1);
        chk("lap_head_first", lap_head, 20'd1);
        lap = 1'b1; lap_pop = 1'b1; step(); lap = 1'b0; lap_pop = 1'b0;
        chk("lap_poppush_count", lap_count, 4);
        chk("lap_poppush_head", lap_head, 20'd2);
        repeat (4) begin lap_pop = 1'b1; step(); lap_pop = 1'b0; end
        chk("lap_drained", lap_count, 0);
        chk("lap_head_empty", lap_head, 20'd0);
        lap = 1'b1; lap_pop = 1'b1; step(); lap = 1'b0; lap_pop = 1'b0;
        chk("lap_push_empty", lap_count, 1);

        // display hold
        do_clear();
        pulse_start();
        idle(201);
        hold = 1'b1;
        idle(300);
        chk("hold_frozen", {disp_mins, disp_secs, disp_decs}, 20'd20);
        hold = 1'b0;
        step();
        chk("hold_release", {disp_mins, disp_secs, disp_decs}, 20'd50);

        // asynchronous reset mid-count
        do_clear();
        pulse_start();
        idle(3451);
        chk("pre_reset_time", {disp_mins, disp_secs, disp_decs}, {7'd0, 6'd3, 7'd45});
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_disp", {disp_mins, disp_secs, disp_decs}, 20'd0);
        chk("arst_running", running, 0);
        chk("arst_lap_count", lap_count, 0);
        chk("arst_flags", {overflow_flag, done_flag}, 0);
        mreset();
        step();
        rst_n = 1'b1;
        idle(2);

        // lap together with pause captures the pre-toggle time
        pulse_start();
        idle(123);
        lap = 1'b1; start_stop = 1'b1; step(); lap = 1'b0; start_stop = 1'b0;
        chk("lap_pretoggle", lap_head, 20'd12);
        chk("lap_pretoggle_paused", running, 0);

        // randomized traffic
        do_clear();
        for (int i = 0; i < 5000; i++) begin
            start_stop = ($urandom_range(0, 59) == 0);
            clear      = ($urandom_range(0, 499) == 0);
            load       = ($urandom_range(0, 29) == 0);
            lap        = ($urandom_range(0, 19) == 0);
            lap_pop    = ($urandom_range(0, 24) == 0);
            load_mins  = 7'($urandom_range(0, 127));
            load_secs  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 49) == 0) hold = ~hold;
            if ($urandom_range(0, 99) == 0) mode_down = ~mode_down;
            step();
        end
        {start_stop, clear, load, lap, lap_pop, hold} = '0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
